// File: rtl/latency_capture.sv
// latency_capture: CPU-bus display-to-sensor latency timer with a result FIFO.
// Defining LATCAP_MINMAX_EN adds min/max tracking of pushed results on addresses 6/7.
module latency_capture #(
    parameter int PRESCALE      = 5,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [1:0]  wr,
    input  logic [2:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        vblank,
    input  logic        hdmi_vblank,
    input  logic [6:0]  user_in,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_START, MEASURE, HOLDOFF} state_t;

    state_t        state, state_n;
    logic [3:0]    s1, s2, prev;
    logic          sens_f, sens;
    logic [7:0]    fcnt, filt_q;
    logic [PW-1:0] pre;
    logic          tick;
    logic [31:0]   cnt, cnt_inc;
    logic [15:0]   hcnt, hold_q;
    logic [5:0]    ctrl;
    logic          irq_en, ovf, tmo, rd_d, we_d, we;
    logic          wr_lo, wr_hi, arm_off, start_ev, stop_ev;
    logic          push, push_ok, pop, full, end_ev, start_take, to_set;
    logic [3:0]    start_edges;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic [15:0]   mm_min, mm_max;
    logic          unused_ok;

    assign unused_ok   = ^user_in[6:2];
    assign we          = cs & |wr;
    assign wr_lo       = we & ~we_d & wr[0];
    assign wr_hi       = we & ~we_d & wr[1];
    assign arm_off     = wr_lo && address == 3'd0 && !din[0];
    assign sens        = (filt_q == 8'd0) ? s2[3] : sens_f;
    // Index 3 of start_edges is tied low: the reserved source never fires.
    assign start_edges = {1'b0, ctrl[4] ? prev[2:0] & ~s2[2:0] : s2[2:0] & ~prev[2:0]};
    assign start_ev    = start_edges[ctrl[3:2]];
    assign stop_ev     = ctrl[5] ? prev[3] & ~sens : sens & ~prev[3];
    assign tick        = pre == PW'(PRESCALE - 1);
    assign cnt_inc     = (tick && cnt != '1) ? cnt + 32'd1 : cnt;
    assign full        = count == CW'(FIFO_DEPTH);
    assign pop         = rd_d & ~rd & cs & (address == 3'd3) & (count != '0);
    assign push_ok     = push & (~full | pop);
    assign head        = (count != '0) ? mem[rp] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            sens_f <= 1'b0;
            fcnt   <= '0;
        end else begin
            s1   <= {user_in[0], user_in[1], hdmi_vblank, vblank};
            s2   <= s1;
            prev <= {sens, s2[2:0]};
            if (filt_q == 8'd0 || s2[3] == sens_f || fcnt + 8'd1 == filt_q) begin
                fcnt   <= '0;
                sens_f <= s2[3];
            end else
                fcnt <= fcnt + 8'd1;
        end
    end

    always_comb begin
        state_n    = state;
        push       = 1'b0;
        to_set     = 1'b0;
        end_ev     = 1'b0;
        start_take = 1'b0;
        case (state)
            IDLE:       state_n = ctrl[0] ? WAIT_START : IDLE;
            WAIT_START: begin
                start_take = start_ev;
                state_n    = start_ev ? MEASURE : WAIT_START;
            end
            MEASURE: if (stop_ev || cnt >= 32'(TIMEOUT_TICKS)) begin
                end_ev  = 1'b1;
                push    = stop_ev;
                to_set  = !stop_ev;
                state_n = !ctrl[1] ? IDLE : (hold_q == 16'd0) ? WAIT_START : HOLDOFF;
            end
            default:    state_n = (hcnt >= hold_q) ? WAIT_START : HOLDOFF;
        endcase
        if (arm_off) begin
            state_n    = IDLE;
            push       = 1'b0;
            to_set     = 1'b0;
            end_ev     = 1'b0;
            start_take = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ctrl   <= '0;
            irq_en <= 1'b0;
            hold_q <= '0;
            filt_q <= '0;
            ovf    <= 1'b0;
            tmo    <= 1'b0;
            rd_d   <= 1'b0;
            we_d   <= 1'b0;
            pre    <= '0;
            cnt    <= '0;
            hcnt   <= '0;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            state <= state_n;
            rd_d  <= rd;
            we_d  <= we;
            if (wr_lo && address == 3'd0)
                ctrl <= din[5:0];
            else if (end_ev && !ctrl[1])
                ctrl[0] <= 1'b0;
            if (wr_hi && address == 3'd0) irq_en <= din[8];
            if (wr_lo && address == 3'd4) hold_q[7:0] <= din[7:0];
            if (wr_hi && address == 3'd4) hold_q[15:8] <= din[15:8];
            if (wr_lo && address == 3'd5) filt_q <= din[7:0];
            ovf   <= (ovf & ~(wr_lo && address == 3'd1 && din[5])) | (push & full & ~pop);
            tmo   <= (tmo & ~(wr_lo && address == 3'd1 && din[6])) | to_set;
            pre   <= (start_take || end_ev || tick) ? '0 : pre + PW'(1);
            cnt   <= start_take ? '0 : (state == MEASURE) ? cnt_inc : cnt;
            hcnt  <= end_ev ? '0 : (state == HOLDOFF && tick) ? hcnt + 16'd1 : hcnt;
            wp    <= wp + AW'(push_ok);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push_ok) - CW'(pop);
            irq   <= irq_en & (count != '0);
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wp] <= cnt_inc;

`ifdef LATCAP_MINMAX_EN
    logic [15:0] sat;
    assign sat = (cnt_inc[31:16] != 16'd0) ? 16'hFFFF : cnt_inc[15:0];

    // Dropped pushes still count toward min/max, so key on push rather than push_ok.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_min <= 16'hFFFF;
            mm_max <= 16'h0000;
        end else if (wr_lo && address == 3'd1 && din[7]) begin
            mm_min <= 16'hFFFF;
            mm_max <= 16'h0000;
        end else if (push) begin
            if (sat < mm_min) mm_min <= sat;
            if (sat > mm_max) mm_max <= sat;
        end
    end
`else
    assign mm_min = '0;
    assign mm_max = '0;
`endif

    always_comb begin
        dout = 16'h0000;
        if (cs)
            case (address)
                3'd0:    dout = {7'd0, irq_en, 2'd0, ctrl};
                3'd1:    dout = {9'd0, tmo, ovf, 4'(count), state != IDLE};
                3'd2:    dout = head[31:16];
                3'd3:    dout = head[15:0];
                3'd4:    dout = hold_q;
                3'd5:    dout = {8'd0, filt_q};
                3'd6:    dout = mm_min;
                default: dout = mm_max;
            endcase
    end
endmodule

// File: tb/tb_latency_capture.sv
// tb_latency_capture: directed self-checking bench for latency_capture.
`timescale 1ns/1ps
module tb_latency_capture;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  wr = 2'b00;
    logic [2:0]  address = 3'd0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        vblank = 1'b0;
    logic        hdmi_vblank = 1'b0;
    logic [6:0]  user_in = 7'd0;
    logic        irq;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    latency_capture #(.PRESCALE(5), .FIFO_DEPTH(8), .TIMEOUT_TICKS(200)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .rd(rd), .wr(wr), .address(address),
        .din(din), .dout(dout), .vblank(vblank), .hdmi_vblank(hdmi_vblank),
        .user_in(user_in), .irq(irq)
    );

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; address = a; din = d; wr = 2'b11;
        @(negedge clk);
        wr = 2'b00; cs = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; address = a; rd = 1'b1;
        #1 d = dout;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic bus_pop(output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; address = 3'd3; rd = 1'b1;
        #1 d = dout;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic measure(input logic [15:0] ctrl_word, input int n);
        bus_write(3'd0, ctrl_word);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        repeat (n) @(negedge clk);
        user_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        vblank = 1'b0; user_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        repeat (2) @(negedge clk);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL reset_dout_nocs: got %h want 0000", dout); end
        reset_n = 1'b1;
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_status: got %h want 0000", d); end
        bus_read(3'd0, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_ctrl: got %h want 0000", d); end
        bus_read(3'd2, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_result_hi: got %h want 0000", d); end
    endtask

    task automatic test_single();
        logic [15:0] d;
        bus_write(3'd0, 16'h0001);
        repeat (3) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0001) begin fails++; $display("FAIL single_busy: got %h want 0001", d); end
        @(negedge clk);
        vblank = 1'b1;
        repeat (500) @(negedge clk);
        user_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0002) begin fails++; $display("FAIL single_status: got %h want 0002", d); end
        bus_read(3'd2, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL single_hi: got %h want 0000", d); end
        bus_pop(d);
        tests++; if (d < 16'd99 || d > 16'd101) begin fails++; $display("FAIL single_lo: got %0d want 99..101", d); end
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL single_popped: got %h want 0000", d); end
        bus_read(3'd0, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL single_arm_clear: got %h want 0000", d); end
        vblank = 1'b0; user_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        logic [15:0] d;
        bus_write(3'd0, 16'h0001);
        repeat (3) @(negedge clk);
        vblank = 1'b1; user_in[0] = 1'b1;
        repeat (100) @(negedge clk);
        vblank = 1'b0;
        repeat (20) @(negedge clk);
        vblank = 1'b1;
        repeat (30) @(negedge clk);
        user_in[0] = 1'b0;
        repeat (150) @(negedge clk);
        user_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0002) begin fails++; $display("FAIL same_cycle_status: got %h want 0002", d); end
        bus_pop(d);
        tests++; if (d < 16'd59 || d > 16'd61) begin fails++; $display("FAIL same_cycle_value: got %0d want 59..61", d); end
        vblank = 1'b0; user_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_filter();
        logic [15:0] d;
        bus_write(3'd5, 16'h0004);
        bus_write(3'd0, 16'h0001);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        repeat (100) @(negedge clk);
        user_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        user_in[0] = 1'b0;
        repeat (97) @(negedge clk);
        user_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0002) begin fails++; $display("FAIL filter_status: got %h want 0002", d); end
        bus_pop(d);
        tests++; if (d < 16'd39 || d > 16'd41) begin fails++; $display("FAIL filter_value: got %0d want 39..41", d); end
        vblank = 1'b0; user_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        bus_write(3'd5, 16'h0000);
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        bus_write(3'd4, 16'd10);
        bus_write(3'd0, 16'h0103);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            vblank = 1'b1;
            repeat (100) @(negedge clk);
            user_in[0] = 1'b1;
            repeat (5) @(negedge clk);
            vblank = 1'b0; user_in[0] = 1'b0;
            repeat (80) @(negedge clk);
        end
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0031) begin fails++; $display("FAIL overflow_status: got %h want 0031", d); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL overflow_irq: got %b want 1", irq); end
        bus_write(3'd1, 16'h0020);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0011) begin fails++; $display("FAIL overflow_clear: got %h want 0011", d); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL overflow_irq_held: got %b want 1", irq); end
    endtask

    task automatic test_pop_push_full();
        logic [15:0] d;
        @(negedge clk);
        vblank = 1'b1;
        repeat (250) @(negedge clk);
        user_in[0] = 1'b1; cs = 1'b1; address = 3'd3; rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0011) begin fails++; $display("FAIL popfull_status: got %h want 0011", d); end
        vblank = 1'b0; user_in[0] = 1'b0;
        bus_write(3'd0, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            bus_pop(d);
            tests++;
            if (i < 7 ? (d < 16'd19 || d > 16'd21) : (d < 16'd49 || d > 16'd51)) begin
                fails++;
                $display("FAIL popfull_entry%0d: got %0d want %0s", i, d, i < 7 ? "19..21" : "49..51");
            end
        end
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL popfull_empty: got %h want 0000", d); end
        repeat (2) @(negedge clk);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL popfull_irq_low: got %b want 0", irq); end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        bus_write(3'd0, 16'h0001);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        repeat (1100) @(negedge clk);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0040) begin fails++; $display("FAIL timeout_status: got %h want 0040", d); end
        bus_read(3'd0, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL timeout_arm: got %h want 0000", d); end
        bus_write(3'd1, 16'h0040);
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL timeout_clear: got %h want 0000", d); end
        vblank = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_minmax();
        logic [15:0] d;
`ifdef LATCAP_MINMAX_EN
        bus_write(3'd1, 16'h0080);
        bus_read(3'd6, d);
        tests++; if (d !== 16'hFFFF) begin fails++; $display("FAIL minmax_min_clear: got %h want ffff", d); end
        bus_read(3'd7, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL minmax_max_clear: got %h want 0000", d); end
        measure(16'h0001, 150);
        measure(16'h0001, 300);
        bus_read(3'd6, d);
        tests++; if (d < 16'd29 || d > 16'd31) begin fails++; $display("FAIL minmax_min: got %0d want 29..31", d); end
        bus_read(3'd7, d);
        tests++; if (d < 16'd59 || d > 16'd61) begin fails++; $display("FAIL minmax_max: got %0d want 59..61", d); end
        bus_pop(d);
        bus_pop(d);
`else
        bus_write(3'd1, 16'h0080);
        bus_read(3'd6, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL minmax_off_6: got %h want 0000", d); end
        bus_read(3'd7, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL minmax_off_7: got %h want 0000", d); end
        bus_read(3'd1, d);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL minmax_off_status: got %h want 0000", d); end
`endif
    endtask

    task automatic test_async_reset();
        measure(16'h0101, 100);
        bus_write(3'd0, 16'h0101);
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        repeat (50) @(negedge clk);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL areset_pre_irq: got %b want 1", irq); end
        #1 reset_n = 1'b0;
        #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL areset_irq: got %b want 0", irq); end
        cs = 1'b1; address = 3'd1;
        #1;
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL areset_status: got %h want 0000", dout); end
        address = 3'd0;
        #1;
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL areset_ctrl: got %h want 0000", dout); end
        cs = 1'b0; vblank = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_filter();
        test_overflow();
        test_pop_push_full();
        test_timeout();
        test_minmax();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
        $fatal(1);
    end
endmodule
